// File: rtl/cpu_prog_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_seq
//  Brief    : Loads a byte program and plays it into a cpu "in" port, holding
//             each byte HOLD cycles, and captures cpu_out after result opcodes.
//             Optional macro CPU_PROG_SEQ_LOOP_EN: wrap playback while start=1.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_prog_seq #(
    parameter int DEPTH = 16,
    parameter int HOLD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       load_clr,
    input  logic       start,
    output logic [7:0] instr,
    output logic       cpu_reset,
    input  logic [7:0] cpu_out,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [7:0] result_data
);

    localparam int         PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         LW          = $clog2(DEPTH + 1);
    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      hold_q, hold_d;
    logic            data_q, data_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic [7:0]      mem_q [DEPTH];

    logic            mem_we;
    logic [PW-1:0]   mem_waddr;
    logic [7:0]      cur_byte;
    logic [3:0]      cur_nib;
    logic            last_hold;
    logic            last_entry;
    logic            takes_data;
    logic            captures;

    assign cur_byte   = mem_q[ptr_q];
    assign cur_nib    = cur_byte[7:4];
    assign last_hold  = (hold_q == C_HOLD_LAST);
    assign last_entry = (LW'(ptr_q) == (len_q - LW'(1)));
    // Classification only applies to opcode bytes; data bytes are opaque.
    assign takes_data = !data_q && ((cur_nib == 4'b1000) || (cur_nib == 4'b0110) ||
                                    (cur_nib == 4'b0111));
    assign captures   = !data_q && ((cur_nib == 4'b1100) || (cur_nib == 4'b1011));

    assign load_ready   = (state_q == S_IDLE) && (len_q < LW'(DEPTH));
    assign instr        = (state_q == S_RUN) ? cur_byte : 8'h00;
    assign cpu_reset    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign result_valid = res_valid_q;
    assign result_data  = res_data_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        data_d      = data_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        mem_we      = 1'b0;
        mem_waddr   = len_q[PW-1:0];

        case (state_q)
            S_IDLE: begin
                if (load_clr) begin
                    len_d = '0;
                end else if (load_valid && load_ready) begin
                    mem_we = 1'b1;
                    len_d  = len_q + LW'(1);
                end
                // Decision uses the updated length so a same-cycle load plays.
                if (start) begin
                    if (len_d != '0) begin
                        state_d = S_RUN;
                        ptr_d   = '0;
                        hold_d  = '0;
                        data_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (last_hold) begin
                    hold_d      = '0;
                    data_d      = takes_data;
                    res_valid_d = captures;
                    if (captures) begin
                        res_data_d = cpu_out;
                    end
                    if (last_entry) begin
                        ptr_d = '0;
`ifdef CPU_PROG_SEQ_LOOP_EN
                        if (!start) begin
                            state_d = S_DRAIN;
                        end
`else
                        state_d = S_DRAIN;
`endif
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            data_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            data_q      <= data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Program storage survives reset and load_clr; only len is cleared.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpu_prog_seq
//  Brief    : Self-checking bench; two instances (HOLD=1, HOLD=3) share inputs
//             and are compared against a queue-based playback model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_seq;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_clr = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cpu_out = 8'h00;

    logic       ready_a, cpurst_a, busy_a, done_a, rv_a;
    logic [7:0] instr_a, rd_a;
    logic       ready_b, cpurst_b, busy_b, done_b, rv_b;
    logic [7:0] instr_b, rd_b;
    logic [19:0] obs_a, obs_b;

    assign obs_a = {instr_a, cpurst_a, busy_a, done_a, rv_a, rd_a};
    assign obs_b = {instr_b, cpurst_b, busy_b, done_b, rv_b, rd_b};

    cpu_prog_seq #(.DEPTH(DEPTH), .HOLD(1)) u_dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_a), .load_clr(load_clr), .start(start), .instr(instr_a),
        .cpu_reset(cpurst_a), .cpu_out(cpu_out), .busy(busy_a), .done(done_a),
        .result_valid(rv_a), .result_data(rd_a)
    );

    cpu_prog_seq #(.DEPTH(DEPTH), .HOLD(3)) u_dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_b), .load_clr(load_clr), .start(start), .instr(instr_b),
        .cpu_reset(cpurst_b), .cpu_out(cpu_out), .busy(busy_b), .done(done_b),
        .result_valid(rv_b), .result_data(rd_b)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] prog [$];
    logic [7:0] hist [0:255];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    // Walk the program from the start to find whether entry idx is a result opcode.
    function automatic bit is_capture(int idx);
        bit         dat = 1'b0;
        logic [7:0] b;
        for (int i = 0; i < idx; i++) begin
            b = prog[i];
            if (dat) dat = 1'b0;
            else     dat = (b[7:4] inside {4'h8, 4'h6, 4'h7});
        end
        b = prog[idx];
        return !dat && (b[7:4] inside {4'hC, 4'hB});
    endfunction

    // Expected {instr, cpu_reset, busy, done, result_valid, result_data} k cycles after start.
    function automatic logic [19:0] expect_at(int h, int k, logic [7:0] last);
        int         n   = prog.size();
        logic [7:0] ins = 8'h00;
        logic       cr  = 1'b1;
        logic       bz  = 1'b0;
        logic       dn  = 1'b0;
        logic       rv  = 1'b0;
        logic [7:0] rd  = last;
        if (n == 0) begin
            dn = (k == 0);
        end else if (k < n * h) begin
            ins = prog[k / h]; cr = 1'b0; bz = 1'b1;
        end else if (k == n * h) begin
            cr = 1'b0; bz = 1'b1;
        end else if (k == n * h + 1) begin
            dn = 1'b1;
        end
        if (n > 0 && k >= 1 && k <= n * h && (k % h) == 0 && is_capture(k / h - 1)) begin
            rv = 1'b1;
            rd = hist[k - 1];
        end
        return {ins, cr, bz, dn, rv, rd};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_byte(input logic [7:0] b, input bit with_start);
        bit exp_rdy = (prog.size() < DEPTH);
        load_valid = 1'b1;
        load_data  = b;
        start      = with_start;
        n_total++;
        if (ready_a !== exp_rdy || ready_b !== exp_rdy)
            $display("FAIL load_ready: got %b/%b expected %b", ready_a, ready_b, exp_rdy);
        else n_pass++;
        if (exp_rdy) prog.push_back(b);
        if (!with_start) begin
            step();
            load_valid = 1'b0;
        end
    endtask

    // load_clr with a same-cycle load: clear must win.
    task automatic clear_prog();
        load_clr   = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        step();
        load_clr   = 1'b0;
        load_valid = 1'b0;
        prog.delete();
        n_total++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1)
            $display("FAIL clear_ready: got %b/%b expected 1", ready_a, ready_b);
        else n_pass++;
    endtask

    task automatic play(input string nm, input bit inject);
        int          span = 3 * prog.size() + 3;
        logic [19:0] ea, eb;
        start = 1'b1;
        step();
        start = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k < span; k++) begin
            cpu_out = 8'($urandom);
            hist[k] = cpu_out;
            ea = expect_at(1, k, last_a);
            eb = expect_at(3, k, last_b);
            last_a = ea[7:0];
            last_b = eb[7:0];
            n_total += 2;
            if (obs_a !== ea) $display("FAIL %s h1 cyc %0d: got %h expected %h", nm, k, obs_a, ea);
            else n_pass++;
            if (obs_b !== eb) $display("FAIL %s h3 cyc %0d: got %h expected %h", nm, k, obs_b, eb);
            else n_pass++;
            if (inject && k == 0) begin
                start = 1'b1; load_valid = 1'b1; load_data = 8'hC1; load_clr = 1'b1;
            end
            step();
            start = 1'b0; load_valid = 1'b0; load_clr = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        prog.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        n_total++;
        if (obs_a !== 20'h00800 || obs_b !== 20'h00800 || ready_a !== 1'b1 || ready_b !== 1'b1)
            $display("FAIL reset: got %h/%h rdy %b/%b expected 00800 rdy 1", obs_a, obs_b, ready_a, ready_b);
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_prog();
        load_byte(8'h60, 0); load_byte(8'h05, 0); load_byte(8'hB0, 0);
        play("basic", 0);
        clear_prog();
        load_byte(8'h83, 0); load_byte(8'hC3, 0); load_byte(8'hC3, 0);
        play("hold", 0);
    endtask

    task automatic test_random();
        logic [3:0] nibs [8] = '{4'h8, 4'h6, 4'h7, 4'hC, 4'hB, 4'h2, 4'hF, 4'h0};
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(2, 6);
            clear_prog();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = {nibs[$urandom_range(0, 7)], 4'($urandom)};
                load_byte(b, (i == n - 1) && it[0]);
            end
            play("random", it[1]);
        end
    endtask

    task automatic test_back_to_back();
        play("replay1", 0);
        play("replay2", 0);
    endtask

    task automatic test_full();
        clear_prog();
        for (int i = 0; i < DEPTH; i++) load_byte({4'hC, 4'(i)}, 0);
        n_total++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0)
            $display("FAIL full_ready: got %b/%b expected 0", ready_a, ready_b);
        else n_pass++;
        load_byte(8'h11, 0);
        play("full", 0);
        clear_prog();
        play("empty", 0);
    endtask

    task automatic test_midrun_reset();
        clear_prog();
        for (int i = 0; i < 5; i++) load_byte({4'hC, 4'(i)}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        prog.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (obs_a !== 20'h00800 || obs_b !== 20'h00800)
                $display("FAIL midrun_reset cyc %0d: got %h/%h expected 00800", k, obs_a, obs_b);
            else n_pass++;
            step();
        end
        play("after_reset", 0);
    endtask

`ifdef CPU_PROG_SEQ_LOOP_EN
    task automatic test_loop();
        bit seen_a = 1'b0;
        bit seen_b = 1'b0;
        clear_prog();
        load_byte(8'h20, 0); load_byte(8'h30, 0);
        start = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            n_total++;
            if (instr_a !== prog[k % 2] || instr_b !== prog[(k / 3) % 2] || done_a || done_b)
                $display("FAIL loop cyc %0d: got %h/%h done %b/%b expected %h/%h done 0",
                         k, instr_a, instr_b, done_a, done_b, prog[k % 2], prog[(k / 3) % 2]);
            else n_pass++;
            step();
        end
        start = 1'b0;
        for (int k = 0; k < 20 && !(seen_a && seen_b); k++) begin
            step();
            if (done_a) seen_a = 1'b1;
            if (done_b) seen_b = 1'b1;
        end
        n_total++;
        if (!seen_a || !seen_b) $display("FAIL loop_done: got %b/%b expected 1/1", seen_a, seen_b);
        else n_pass++;
        step(); step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step();
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_full();
        test_midrun_reset();
`ifdef CPU_PROG_SEQ_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_prog_seq.md
CPU_PROG_SEQ -- requirements
Module: cpu_prog_seq

Interface
REQ-001 Parameter DEPTH, default 16: number of program-memory entries, each 8 bits.
REQ-002 Parameter HOLD, default 1, legal range 1..255: number of clk cycles each program byte is driven on instr.
REQ-003 Ports, all synchronous to clk:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load_data is valid.
- load_data  in  8  program byte to append.
- load_ready  out  1  append is accepted this cycle.
- load_clr  in  1  empty the program (length := 0).
- start  in  1  begin playback.
- instr  out  8  byte driven to the cpu "in" port.
- cpu_reset  out  1  drives the cpu "reset" port.
- cpu_out  in  8  cpu "out" port.
- busy  out  1  playback in progress.
- done  out  1  one-cycle end-of-playback pulse.
- result_valid  out  1  one-cycle pulse: result_data is valid.
- result_data  out  8  captured cpu_out.

Function
REQ-004 States: IDLE, RUN, DRAIN, DONE. Only states RUN and DRAIN assert busy.
REQ-005 IDLE: load_ready = (len < DEPTH), combinational. Outside IDLE, load_ready = 0.
REQ-006 Handshake: load_valid & load_ready writes load_data to mem[len] and increments len. A byte offered while load_ready = 0 is dropped and len is unchanged.
REQ-007 load_clr in IDLE sets len := 0 and takes priority over a same-cycle load. Memory contents are not erased. load_clr is ignored outside IDLE.
REQ-008 IDLE & start & len > 0 -> RUN on the next cycle. A load in the same cycle is written first and is included in the playback length.
REQ-009 IDLE & start & len == 0 -> DONE; no byte is issued.
REQ-010 RUN:
- cpu_reset = 0.
- instr = mem[ptr], held for exactly HOLD cycles per entry.
- ptr counts 0..len-1, starting at 0 on entry to RUN.
- The first byte appears on instr in the first RUN cycle.
REQ-011 After the last hold cycle of entry len-1: RUN -> DRAIN for 1 cycle (instr = 8'h00, cpu_reset = 0), then DONE for 1 cycle (done = 1), then IDLE.
REQ-012 In IDLE and DONE: instr = 8'h00 and cpu_reset = 1.
REQ-013 Byte classification:
- The byte at ptr 0 is an opcode byte.
- An opcode byte with upper nibble 4'b1000, 4'b0110 or 4'b0111 marks the next byte as a data byte.
- Every other byte is an opcode byte.
- The data-byte flag clears on entry to RUN.
REQ-014 Result capture:
- Applies to an opcode byte with upper nibble 4'b1100 or 4'b1011.
- On the cycle after its final hold cycle, result_valid = 1 and result_data = cpu_out sampled at that clock edge.
- If that byte is entry len-1, the capture occurs in DRAIN.
- Data bytes never trigger a capture.
REQ-015 result_data holds its last captured value until the next capture.
REQ-016 len, mem and the last result are retained across playbacks. A start in IDLE after DONE replays the same program.
REQ-017 start, load_valid and load_clr are ignored in RUN, DRAIN and DONE.

Reset
REQ-018 reset forces, on the next edge: state = IDLE, len = 0, ptr = 0, hold counter = 0, data-byte flag = 0.
REQ-019 Output values after reset: instr = 8'h00, cpu_reset = 1, busy = 0, done = 0, result_valid = 0, result_data = 8'h00.
REQ-020 reset in any state, including mid-RUN, aborts playback with no done pulse and no result pulse.

Configuration
REQ-021 Macro CPU_PROG_SEQ_LOOP_EN.
- Defined: at the end of entry len-1, if start = 1 the sequencer wraps ptr to 0 and stays in RUN, with no DRAIN, no done and cpu_reset held at 0. The data-byte flag carries across the wrap. If start = 0, it proceeds to DRAIN per REQ-011.
- Undefined: the sequencer follows REQ-011 unconditionally, and start is sampled only in IDLE.

Verification
REQ-022 Load 3 bytes (8'h60, 8'h05, 8'hB0), HOLD = 1, pulse start -> instr shows 60, 05, B0 on consecutive cycles. Then DRAIN 00, then done for 1 cycle. result_valid pulses once, in DRAIN, with result_data = cpu_out at that edge.
REQ-023 Load 8'h83, 8'hC3 (data byte with 1100 nibble), 8'hC3, HOLD = 3 -> each byte is held 3 cycles. Exactly one result_valid pulse, 3 cycles after 8'hC3 first appears at ptr 2.
REQ-024 Load 16 bytes with DEPTH = 16 -> load_ready = 0. A 17th load_valid is dropped and len stays 16. load_clr then sets load_ready = 1 and len = 0.
REQ-025 start with len = 0 -> done pulses 1 cycle later, busy never asserts, and cpu_reset stays 1.
REQ-026 reset asserted on the 2nd RUN cycle of a 5-byte program -> the next cycle shows IDLE, instr = 00, cpu_reset = 1, len = 0, and no done pulse.
REQ-027 With CPU_PROG_SEQ_LOOP_EN defined and start held high on a 2-byte program 8'h20, 8'h30 -> instr shows 20, 30, 20, 30... with no done pulse. Deasserting start -> the current pass completes, then DRAIN, then done.
